// File: rtl/craft_pkg.sv
// Shared types and constants for the CRAFT nibble-serial round sequencer.
// Holds the FSM state encoding, state-register mode selects and round geometry.
package craft_pkg;

    localparam int unsigned CRAFT_ROUNDS = 32;
    localparam int unsigned NIBBLES      = 16;

    typedef logic [1:0] mode_t;

    // Mode selects as {cs0, cs1} driven to the state register
    localparam mode_t MODE_LOAD  = 2'b10;
    localparam mode_t MODE_SHIFT = 2'b00;
    localparam mode_t MODE_MIX   = 2'b11;
    localparam mode_t MODE_PERM  = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        PERM,
        DONE
    } state_t;

    function automatic mode_t round_mode(input logic [3:0] nibble, input int unsigned mc_first);
        return (32'(nibble) >= mc_first) ? MODE_MIX : MODE_SHIFT;
    endfunction

endpackage

// File: rtl/craft_round_counter.sv
// Nibble-slot and round counters for the CRAFT sequencer.
// hold freezes both counters and dominates clear and the increments.
module craft_round_counter
    import craft_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = CRAFT_ROUNDS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       clear,
    input  logic       inc_nibble,
    input  logic       inc_round,
    output logic [4:0] round_idx,
    output logic [3:0] nibble_idx,
    output logic       last_round,
    output logic       nibble_wrap
);

    always_ff @(posedge clk) begin
        if (rst) begin
            round_idx  <= '0;
            nibble_idx <= '0;
        end else if (!hold) begin
            if (clear) begin
                round_idx  <= '0;
                nibble_idx <= '0;
            end else begin
                if (inc_nibble) begin
                    nibble_idx <= nibble_idx + 4'd1;
                end
                // Saturate at the final round; DONE is always taken before a wrap
                if (inc_round && !last_round) begin
                    round_idx <= round_idx + 5'd1;
                end
            end
        end
    end

    assign last_round  = (round_idx == 5'(NUM_ROUNDS - 1));
    assign nibble_wrap = (nibble_idx == 4'(NIBBLES - 1));

endmodule

// File: rtl/craft_round_sequencer.sv
// Control FSM for the CRAFT nibble-serial state register: LOAD, 16-slot ROUND passes
// separated by PERM, then a one-cycle DONE pulse. Only state_ce sees stall combinationally.
module craft_round_sequencer
    import craft_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = CRAFT_ROUNDS,
    parameter int unsigned MC_FIRST   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    output logic       ready,
    output logic       busy,
    output logic       done,
    output logic       state_ce,
    output logic       cs0,
    output logic       cs1,
    output logic [4:0] round_idx,
    output logic [3:0] nibble_idx,
    output logic [1:0] tk_sel,
    output logic       last_round
);

    state_t state;
    state_t state_nxt;
    mode_t  mode;
    logic   run_ce;
    logic   cnt_clear;
    logic   cnt_inc_nibble;
    logic   cnt_inc_round;
    logic   nibble_wrap;

    craft_round_counter #(
        .NUM_ROUNDS(NUM_ROUNDS)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .hold       (stall),
        .clear      (cnt_clear),
        .inc_nibble (cnt_inc_nibble),
        .inc_round  (cnt_inc_round),
        .round_idx  (round_idx),
        .nibble_idx (nibble_idx),
        .last_round (last_round),
        .nibble_wrap(nibble_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (!stall) state_nxt = ROUND;
            ROUND:   if (!stall && nibble_wrap) state_nxt = last_round ? DONE : PERM;
            PERM:    if (!stall) state_nxt = ROUND;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counter strobes are gated by hold inside the counter, so stall needs no term here
    always_comb begin
        ready          = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        run_ce         = 1'b0;
        mode           = MODE_SHIFT;
        cnt_clear      = 1'b0;
        cnt_inc_nibble = 1'b0;
        cnt_inc_round  = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
            end
            LOAD: begin
                busy      = 1'b1;
                run_ce    = 1'b1;
                mode      = MODE_LOAD;
                cnt_clear = 1'b1;
            end
            ROUND: begin
                busy           = 1'b1;
                run_ce         = 1'b1;
                mode           = round_mode(nibble_idx, MC_FIRST);
                cnt_inc_nibble = 1'b1;
            end
            PERM: begin
                busy          = 1'b1;
                run_ce        = 1'b1;
                mode          = MODE_PERM;
                cnt_inc_round = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign state_ce   = run_ce & ~stall;
    assign {cs0, cs1} = mode;
    assign tk_sel     = round_idx[1:0];

endmodule

// File: tb/tb_craft_round_sequencer.sv
// Scoreboard bench for craft_round_sequencer: directed runs push a per-cycle expected
// trace; a negedge monitor pops and compares, and checks idle outputs between records.
module tb_craft_round_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stall;
    logic       ready;
    logic       busy;
    logic       done;
    logic       state_ce;
    logic       cs0;
    logic       cs1;
    logic [4:0] round_idx;
    logic [3:0] nibble_idx;
    logic [1:0] tk_sel;
    logic       last_round;

    craft_round_sequencer #(
        .NUM_ROUNDS(32),
        .MC_FIRST  (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stall     (stall),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .state_ce  (state_ce),
        .cs0       (cs0),
        .cs1       (cs1),
        .round_idx (round_idx),
        .nibble_idx(nibble_idx),
        .tk_sel    (tk_sel),
        .last_round(last_round)
    );

    typedef struct {
        int         cyc;
        logic       ready;
        logic       busy;
        logic       done;
        logic       ce;
        logic [1:0] mode;
        logic       cm;
        logic [4:0] rnd;
        logic [3:0] nib;
        logic [1:0] tk;
        logic       last;
        logic       ci;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;
    int   perm_cnt = 0;
    logic mon_en   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic add(input int t, input logic rdy, input logic bsy, input logic dn,
                       input logic ce, input logic [1:0] md, input logic cm,
                       input int r, input int n, input logic ci, input int cutoff);
        exp_t e;
        if (t > cutoff) return;
        e.cyc = t; e.ready = rdy; e.busy = bsy; e.done = dn; e.ce = ce;
        e.mode = md; e.cm = cm; e.rnd = 5'(r); e.nib = 4'(n);
        e.tk = 2'(r % 4); e.last = (r == 31); e.ci = ci;
        exp_q.push_back(e);
    endtask

    // Expected trace of one encryption whose start is sampled at the end of cycle c0;
    // s_len stall cycles are inserted in front of ROUND slot (s_r, s_n).
    task automatic push_run(input int c0, input int s_r, input int s_n, input int s_len,
                            input int cutoff);
        int t;
        t = c0 + 1;
        add(t, 0, 1, 0, 1, 2'b10, 1, 0, 0, 0, cutoff); t++;
        for (int r = 0; r < 32; r++) begin
            for (int n = 0; n < 16; n++) begin
                logic [1:0] md;
                md = (n >= 12) ? 2'b11 : 2'b00;
                if (r == s_r && n == s_n) begin
                    for (int k = 0; k < s_len; k++) begin
                        add(t, 0, 1, 0, 0, md, 1, r, n, 1, cutoff); t++;
                    end
                end
                add(t, 0, 1, 0, 1, md, 1, r, n, 1, cutoff); t++;
            end
            if (r < 31) begin
                add(t, 0, 1, 0, 1, 2'b01, 1, r, 0, 0, cutoff); t++;
            end
        end
        add(t, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0, cutoff);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (state_ce === 1'b1 && cs0 === 1'b0 && cs1 === 1'b1) perm_cnt++;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL missed_record cyc=%0d expected_at=%0d", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                exp_t e;
                logic ok;
                e = exp_q.pop_front();
                ok = (ready === e.ready) && (busy === e.busy) && (done === e.done) &&
                     (state_ce === e.ce);
                if (e.cm) ok = ok && ({cs0, cs1} === e.mode);
                if (e.ci) ok = ok && (round_idx === e.rnd) && (nibble_idx === e.nib) &&
                               (tk_sel === e.tk) && (last_round === e.last);
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL trace cyc=%0d got rdy=%b bsy=%b dn=%b ce=%b cs=%b%b rnd=%0d nib=%0d tk=%0d last=%b want rdy=%b bsy=%b dn=%b ce=%b cs=%b(chk%b) rnd=%0d nib=%0d tk=%0d last=%b(chk%b)",
                             cyc, ready, busy, done, state_ce, cs0, cs1, round_idx, nibble_idx,
                             tk_sel, last_round, e.ready, e.busy, e.done, e.ce, e.mode, e.cm,
                             e.rnd, e.nib, e.tk, e.last, e.ci);
                end
            end else begin
                checks++;
                if (!(ready === 1'b1 && busy === 1'b0 && done === 1'b0 && state_ce === 1'b0)) begin
                    failures++;
                    $display("FAIL idle cyc=%0d got rdy=%b bsy=%b dn=%b ce=%b want rdy=1 bsy=0 dn=0 ce=0",
                             cyc, ready, busy, done, state_ce);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        int c0;
        int p0;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        add(cyc, 1, 0, 0, 0, 2'b00, 1, 0, 0, 1, 1 << 30);
        mon_en = 1'b1;
        rst = 1'b0;
        wait_until(cyc + 3);

        // Plain run with a stray start pulse mid-round; counts PERM cycles
        c0 = cyc; p0 = perm_cnt;
        push_run(c0, -1, -1, 0, 1 << 30);
        start = 1'b1; step(); start = 1'b0;
        wait_until(c0 + 200); start = 1'b1; step(); start = 1'b0;
        wait_until(c0 + 547);
        checks++;
        if (perm_cnt - p0 != 31) begin
            failures++;
            $display("FAIL perm_count got=%0d want=31", perm_cnt - p0);
        end

        // Stall has no effect in IDLE
        stall = 1'b1; repeat (3) step(); stall = 1'b0;
        step();

        // 5-cycle stall at round 7 nibble 3; start and stall during DONE are ignored
        c0 = cyc;
        push_run(c0, 7, 3, 5, 1 << 30);
        start = 1'b1; step(); start = 1'b0;
        wait_until(c0 + 124); stall = 1'b1; repeat (5) step(); stall = 1'b0;
        wait_until(c0 + 550); start = 1'b1; stall = 1'b1; step(); start = 1'b0; stall = 1'b0;
        wait_until(c0 + 555);

        // start held high: second LOAD two cycles after the first done
        c0 = cyc;
        push_run(c0, -1, -1, 0, 1 << 30);
        push_run(c0 + 546, -1, -1, 0, 1 << 30);
        start = 1'b1;
        wait_until(c0 + 547); start = 1'b0;
        wait_until(c0 + 546 + 548);

        // Reset at round 20 nibble 9
        c0 = cyc;
        push_run(c0, -1, -1, 0, c0 + 351);
        add(c0 + 352, 1, 0, 0, 0, 2'b00, 1, 0, 0, 1, 1 << 30);
        start = 1'b1; step(); start = 1'b0;
        wait_until(c0 + 351); rst = 1'b1; step(); rst = 1'b0;
        wait_until(c0 + 372);

        // rst and start together in IDLE: reset wins
        c0 = cyc;
        add(c0 + 1, 1, 0, 0, 0, 2'b00, 1, 0, 0, 1, 1 << 30);
        add(c0 + 2, 1, 0, 0, 0, 2'b00, 1, 0, 0, 1, 1 << 30);
        rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
        wait_until(c0 + 8);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/craft_round_sequencer.md
Name: craft_round_sequencer

Overview:
- Control FSM for the CRAFT nibble-serial state register, which has a 64-bit state, a 4-bit serial in/out and a 2-bit mode select (CS0, CS1).
- Drives the register clock enable and mode selects, and sequences a full 32-round encryption.
- Publishes round and nibble indices so the round-logic datapath (S-box, constants, tweakey) selects the correct constant and tweakey nibble.
- Sits between the top-level start/done handshake and the state register plus round datapath.

Parameters:
- NUM_ROUNDS, 32, number of rounds per encryption; legal range 2..32.
- MC_FIRST, 12, first nibble slot of a round's serial pass that uses column-feed mode (CS0=1, CS1=1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin an encryption; sampled only when ready=1
- stall  input  1  freeze request; holds all counters and the FSM, and forces state_ce=0
- ready  output  1  high in IDLE; start is accepted
- busy  output  1  high from the LOAD cycle through the last ROUND/PERM cycle
- done  output  1  one-cycle pulse; the state register holds the ciphertext
- state_ce  output  1  clock enable to the state register
- cs0  output  1  mode select 0 to the state register
- cs1  output  1  mode select 1 to the state register
- round_idx  output  5  current round, 0..NUM_ROUNDS-1
- nibble_idx  output  4  serial slot within the round pass, 0..15
- tk_sel  output  2  tweakey select, equal to round_idx[1:0]
- last_round  output  1  round_idx == NUM_ROUNDS-1

Behaviour:
- Register modes (cs0,cs1):
  - 10: parallel load.
  - 00: serial rotate.
  - 11: column feed (inserts the datapath nibble).
  - 01: nibble permutation.
- Reset values: FSM=IDLE, ready=1, busy=0, done=0, state_ce=0, cs0=0, cs1=0, round_idx=0, nibble_idx=0. A reset in any state, including mid-round, returns to these values on the next edge. The state register contents are left as they are.
- States and transitions:
  - IDLE: state_ce=0. If start=1, go to LOAD. If rst and start are both high, rst wins.
  - LOAD (1 cycle): state_ce=1, cs0/cs1=10. Clear round_idx and nibble_idx. Go to ROUND.
  - ROUND (16 cycles per round): state_ce=1. Mode is 11 when nibble_idx >= MC_FIRST, otherwise 00. nibble_idx increments each cycle.
  - At nibble_idx=15 in ROUND:
    - If last_round=0: go to PERM.
    - If last_round=1: go to DONE. The final round has no permutation.
  - PERM (1 cycle): state_ce=1, mode 01, nibble_idx wraps to 0, round_idx increments. Go to ROUND.
  - DONE (1 cycle): state_ce=0, done=1, ready=0. Go to IDLE.
- Outputs are registered: each output reflects the current state, with no combinational path from start or stall. The exception is state_ce, which is gated combinationally by stall.
- stall=1 in LOAD, ROUND or PERM:
  - state_ce=0; FSM and counters hold.
  - cs0, cs1, round_idx and nibble_idx keep their values.
  - Stall in IDLE or DONE has no effect. done is never extended or delayed by stall.
- Latency: with NUM_ROUNDS=32 and no stalls, start is accepted at cycle 0 and:
  - LOAD occurs at cycle 1.
  - The first ROUND cycle is cycle 2.
  - done is high at cycle 2 + 32*16 + 31 = 545.
  - Total = NUM_ROUNDS*17 + 1 cycles from start to done. Each stall cycle adds exactly one cycle.
- start while busy or in DONE is ignored; it is neither queued nor restarted.
- Back-to-back operation: start sampled in the first IDLE cycle after DONE is accepted, giving a minimum of 1 idle cycle between operations.
- Counter widths:
  - nibble_idx wraps modulo 16.
  - round_idx never exceeds NUM_ROUNDS-1; there is no wrap because DONE is taken first.

Decomposition:
- Shared package craft_pkg holds:
  - the state enum (IDLE, LOAD, ROUND, PERM, DONE);
  - mode constants MODE_LOAD=2'b10, MODE_SHIFT=2'b00, MODE_MIX=2'b11, MODE_PERM=2'b01;
  - CRAFT_ROUNDS=32 and NIBBLES=16.
- One sub-module, craft_round_counter: nibble and round counters with a hold/clear/increment interface and last_round/wrap flags. The FSM stays in the top module.

Test Plan:
- Reset, then start=1 for 1 cycle → LOAD at cycle 1 with cs0/cs1=10. The mode sequence in round 0 is 00×12 then 11×4, then PERM (01). done pulses at cycle 545. busy is high for cycles 1..544.
- Run NUM_ROUNDS=32 to completion → 31 PERM cycles counted, no PERM after round 31, tk_sel sequence 0,1,2,3,0,… per round.
- stall=1 for 5 cycles at round 7, nibble 3 → state_ce=0 and outputs frozen during the stall; done arrives at cycle 550.
- start held high throughout → second LOAD occurs exactly 2 cycles after the first done (DONE, then IDLE accepts start); start pulses during busy are ignored.
- rst=1 at round 20, nibble 9 → next cycle: ready=1, busy=0, round_idx=0, nibble_idx=0, state_ce=0, and no done pulse.
- rst=1 and start=1 in the same IDLE cycle → stays in IDLE, no LOAD.
